// File: rtl/clkdiv_gen_if.sv
// clkdiv_gen_if: configuration bus for clkdiv_gen.
//   cfg_valid/cfg_ready : shadow write handshake (accepted when both high)
//   cfg_ch              : target channel index
//   cfg_hi/cfg_lo       : high/low phase lengths in refclk cycles
//   cfg_prst            : phase preset (starting count)
//   cfg_en              : channel enable
//   cfg_commit          : one-cycle pulse, copy shadow to active and realign
//   cfg_err             : one-cycle pulse, last write rejected
interface clkdiv_gen_if #(
    parameter int unsigned CNT_W = 9
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_hi;
    logic [CNT_W-1:0] cfg_lo;
    logic [CNT_W:0]   cfg_prst;
    logic             cfg_en;
    logic             cfg_commit;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_hi, cfg_lo, cfg_prst, cfg_en, cfg_commit,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_hi, cfg_lo, cfg_prst, cfg_en, cfg_commit,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clkdiv_gen.sv
// clkdiv_gen: multi-channel digital clock divider with PLL-like lock indication.
//   refclk : reference clock
//   rst    : asynchronous active-high reset
//   cfg    : configuration bus (clkdiv_gen_if slave)
//   outclk : divided clock-enable waveforms, bit i = channel i (registered)
//   locked : all channels realigned and settle time elapsed (registered)
// Each channel counts 0..hi+lo-1 and drives high while the count is below hi.
// Writes land in per-channel shadow registers; a commit copies shadow to
// active and restarts every counter from its preset on the same edge.
module clkdiv_gen #(
    parameter int unsigned N_CLK       = 3,
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic              refclk,
    input  logic              rst,
    clkdiv_gen_if.slave       cfg,
    output logic [N_CLK-1:0]  outclk,
    output logic              locked
);
    localparam int unsigned PW = CNT_W + 1;
    localparam int unsigned SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {StAlign, StSettle, StLocked} state_e;

    state_e            state;
    logic [SW-1:0]     settle;

    logic [CNT_W-1:0]  sh_hi   [N_CLK];
    logic [CNT_W-1:0]  sh_lo   [N_CLK];
    logic [PW-1:0]     sh_prst [N_CLK];
    logic              sh_en   [N_CLK];
    logic [CNT_W-1:0]  act_hi  [N_CLK];
    logic [CNT_W-1:0]  act_lo  [N_CLK];
    logic              act_en  [N_CLK];
    logic [PW-1:0]     cnt     [N_CLK];
    logic [PW-1:0]     period  [N_CLK];

    logic [N_CLK-1:0]  cnt_last;
    logic [N_CLK-1:0]  out_nxt;
    logic              wr_req;
    logic              wr_bad;
    logic [PW-1:0]     wr_period;

    always_comb begin
        wr_period = {1'b0, cfg.cfg_hi} + {1'b0, cfg.cfg_lo};
        wr_req    = cfg.cfg_valid && cfg.cfg_ready;
        wr_bad    = (32'(cfg.cfg_ch) >= N_CLK) || (cfg.cfg_hi == '0) ||
                    (cfg.cfg_lo == '0) || (cfg.cfg_prst >= wr_period);
    end

    always_comb begin
        cnt_last = '0;
        out_nxt  = '0;
        for (int unsigned i = 0; i < N_CLK; i++) begin
            period[i]   = {1'b0, act_hi[i]} + {1'b0, act_lo[i]};
            cnt_last[i] = (cnt[i] == period[i] - PW'(1));
            out_nxt[i]  = act_en[i] && (cnt[i] < {1'b0, act_hi[i]});
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= StAlign;
            settle        <= '0;
            locked        <= 1'b0;
            outclk        <= '0;
            cfg.cfg_ready <= 1'b0;
            cfg.cfg_err   <= 1'b0;
            for (int unsigned i = 0; i < N_CLK; i++) begin
                sh_hi[i]   <= CNT_W'(1);
                sh_lo[i]   <= CNT_W'(1);
                sh_prst[i] <= '0;
                sh_en[i]   <= 1'b0;
                act_hi[i]  <= CNT_W'(1);
                act_lo[i]  <= CNT_W'(1);
                act_en[i]  <= 1'b0;
                cnt[i]     <= '0;
            end
        end else begin
            cfg.cfg_err <= wr_req && wr_bad;

            // Shadow update precedes the ALIGN copy, so a write on the commit
            // edge is picked up by the realignment that follows.
            for (int unsigned i = 0; i < N_CLK; i++) begin
                if (wr_req && !wr_bad && (32'(cfg.cfg_ch) == i)) begin
                    sh_hi[i]   <= cfg.cfg_hi;
                    sh_lo[i]   <= cfg.cfg_lo;
                    sh_prst[i] <= cfg.cfg_prst;
                    sh_en[i]   <= cfg.cfg_en;
                end
            end

            case (state)
                StAlign: begin
                    for (int unsigned i = 0; i < N_CLK; i++) begin
                        act_hi[i] <= sh_hi[i];
                        act_lo[i] <= sh_lo[i];
                        act_en[i] <= sh_en[i];
                        cnt[i]    <= sh_prst[i];
                    end
                    outclk        <= '0;
                    settle        <= '0;
                    locked        <= 1'b0;
                    cfg.cfg_ready <= 1'b1;
                    state         <= StSettle;
                end
                StSettle, StLocked: begin
                    for (int unsigned i = 0; i < N_CLK; i++) begin
                        cnt[i] <= cnt_last[i] ? '0 : cnt[i] + PW'(1);
                    end
                    outclk <= out_nxt;
                    if (cfg.cfg_commit) begin
                        locked        <= 1'b0;
                        cfg.cfg_ready <= 1'b0;
                        state         <= StAlign;
                    end else if (state == StSettle) begin
                        if (settle == SW'(LOCK_CYCLES - 1)) begin
                            locked <= 1'b1;
                            state  <= StLocked;
                        end else begin
                            settle <= settle + SW'(1);
                        end
                    end
                end
                default: state <= StAlign;
            endcase
        end
    end
endmodule
